// File: rtl/video_stream_sink.sv
// AXI4-Stream video terminator: checks SOF/EOL framing against an X_SIZE x Y_SIZE raster, counts frames/errors, latches per-frame checksum.
// One-cycle update latency after each accept; tready is registered and shaped by ready_mode.
module video_stream_sink #(
    parameter int          DATA_WIDTH = 32,
    parameter int          X_SIZE     = 1280,
    parameter int          Y_SIZE     = 720,
    parameter int          CNT_WIDTH  = 16,
    parameter int          TIMEOUT    = 1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    in_stream_aclk,
    input  logic                    periph_resetn,
    input  logic [DATA_WIDTH-1:0]   in_stream_tdata,
    input  logic [DATA_WIDTH/8-1:0] in_stream_tkeep,
    input  logic                    in_stream_tuser,
    input  logic                    in_stream_tlast,
    input  logic                    in_stream_tvalid,
    output logic                    in_stream_tready,
    input  logic [1:0]              ready_mode,
    output logic                    locked,
    output logic [15:0]             x_pos,
    output logic [15:0]             y_pos,
    output logic [CNT_WIDTH-1:0]    frame_count,
    output logic [CNT_WIDTH-1:0]    sof_err_count,
    output logic [CNT_WIDTH-1:0]    eol_err_count,
    output logic                    timeout,
    output logic                    frame_done,
    output logic [31:0]             frame_checksum
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rst_meta;
    logic                   r_rst_sync;
    logic                   r_ready;
    logic [15:0]            r_lfsr;
    logic [15:0]            r_x;
    logic [15:0]            r_y;
    logic [CNT_WIDTH-1:0]   r_frames;
    logic [CNT_WIDTH-1:0]   r_sof_err;
    logic [CNT_WIDTH-1:0]   r_eol_err;
    logic [IW-1:0]          r_idle;
    logic                   r_timeout;
    logic                   r_done;
    logic [31:0]            r_sum;
    logic [31:0]            r_checksum;

    logic                   w_unused;
    logic                   w_accept;
    logic                   w_take;
    logic                   w_origin;
    logic                   w_resync;
    logic                   w_sof_err;
    logic [15:0]            w_bx;
    logic [15:0]            w_by;
    logic [31:0]            w_sum_new;
    logic                   w_at_eol;
    logic                   w_line_end;
    logic                   w_eol_err;
    logic                   w_frame_end;
    logic                   w_ready_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_unused = ^in_stream_tkeep;

    // Async assert, release re-timed to the clock before it reaches the datapath.
    always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_accept    = in_stream_tvalid & r_ready;
    assign w_take      = w_accept & ((r_state == S_LOCKED) | in_stream_tuser);
    assign w_origin    = (r_x == 16'd0) && (r_y == 16'd0);
    // A SOF found away from the origin (or the first SOF in HUNT) restarts the raster here.
    assign w_resync    = (r_state == S_HUNT) || (in_stream_tuser && !w_origin);
    assign w_sof_err   = (r_state == S_LOCKED) && (w_origin ? !in_stream_tuser : in_stream_tuser);
    assign w_bx        = w_resync ? 16'd0 : r_x;
    assign w_by        = w_resync ? 16'd0 : r_y;
    assign w_sum_new   = (w_resync ? 32'd0 : r_sum) + 32'(in_stream_tdata);
    assign w_at_eol    = (w_bx == 16'(X_SIZE - 1));
    assign w_line_end  = w_at_eol | in_stream_tlast;
    assign w_eol_err   = w_at_eol ^ in_stream_tlast;
    assign w_frame_end = w_line_end && (w_by == 16'(Y_SIZE - 1));

    always_comb begin
        w_ready_nxt = 1'b0;
        case (ready_mode)
            2'd0:    w_ready_nxt = 1'b1;
            2'd1:    w_ready_nxt = r_lfsr[15];
            2'd2:    w_ready_nxt = in_stream_tvalid & ~r_ready;
            default: w_ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge in_stream_aclk or negedge r_rst_sync) begin
        if (!r_rst_sync) r_state <= S_HUNT;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_HUNT && w_accept && in_stream_tuser)
            w_state_nxt = S_LOCKED;
    end

    always_ff @(posedge in_stream_aclk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_ready    <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_x        <= '0;
            r_y        <= '0;
            r_frames   <= '0;
            r_sof_err  <= '0;
            r_eol_err  <= '0;
            r_idle     <= '0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_checksum <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_done  <= 1'b0;
            if (w_take) begin
                r_timeout <= 1'b0;
                if (w_sof_err) r_sof_err <= sat_inc(r_sof_err);
                if (w_eol_err) r_eol_err <= sat_inc(r_eol_err);
                if (w_line_end) begin
                    r_x <= '0;
                    if (w_frame_end) begin
                        r_y        <= '0;
                        r_frames   <= sat_inc(r_frames);
                        r_done     <= 1'b1;
                        r_checksum <= w_sum_new;
                        r_sum      <= '0;
                    end else begin
                        r_y   <= w_by + 16'd1;
                        r_sum <= w_sum_new;
                    end
                end else begin
                    r_x   <= w_bx + 16'd1;
                    r_y   <= w_by;
                    r_sum <= w_sum_new;
                end
            end
            if (r_state == S_LOCKED) begin
                if (in_stream_tvalid) begin
                    r_idle <= '0;
                end else begin
                    if (r_idle != IW'(TIMEOUT)) r_idle <= r_idle + 1'b1;
                    if (r_idle >= IW'(TIMEOUT - 1)) r_timeout <= 1'b1;
                end
            end
        end
    end

    assign in_stream_tready = r_ready;
    assign locked           = (r_state == S_LOCKED);
    assign x_pos            = r_x;
    assign y_pos            = r_y;
    assign frame_count      = r_frames;
    assign sof_err_count    = r_sof_err;
    assign eol_err_count    = r_eol_err;
    assign timeout          = r_timeout;
    assign frame_done       = r_done;
    assign frame_checksum   = r_checksum;
endmodule

// File: tb/tb_video_stream_sink.sv
// Bench for video_stream_sink on a 4x3 raster: directed framing cases plus randomized beats against a beat-level reference model.
module tb_video_stream_sink;
    localparam int XS = 4;
    localparam int YS = 3;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [1:0]  mode = 2'd0;
    logic        locked;
    logic [15:0] x_pos, y_pos;
    logic [15:0] frame_count, sof_cnt, eol_cnt;
    logic        tmo, fdone;
    logic [31:0] chksum;

    video_stream_sink #(
        .DATA_WIDTH(32), .X_SIZE(XS), .Y_SIZE(YS), .CNT_WIDTH(16), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)
    ) dut (
        .in_stream_aclk(clk), .periph_resetn(rst_n),
        .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tuser(tuser),
        .in_stream_tlast(tlast), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
        .ready_mode(mode), .locked(locked), .x_pos(x_pos), .y_pos(y_pos),
        .frame_count(frame_count), .sof_err_count(sof_cnt), .eol_err_count(eol_cnt),
        .timeout(tmo), .frame_done(fdone), .frame_checksum(chksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the expected raster position per accepted beat.
    bit          m_locked, m_tmo, m_done, m_rdy, m_pre_lock, m_acc;
    int          m_x, m_y, m_frames, m_sof, m_eol, m_idle, m_rel;
    logic [31:0] m_sum, m_chk;
    logic [15:0] m_lfsr;

    task automatic m_beat(input bit u, input bit l, input logic [31:0] d);
        if (!m_locked) begin
            if (!u) return;
            m_locked = 1; m_x = 0; m_y = 0; m_sum = 0;
        end else if (m_x == 0 && m_y == 0) begin
            if (!u) m_sof++;
        end else if (u) begin
            m_sof++; m_x = 0; m_y = 0; m_sum = 0;
        end
        m_sum = m_sum + d;
        m_tmo = 0;
        if (l != (m_x == XS - 1)) m_eol++;
        if (l || m_x == XS - 1) begin
            m_x = 0;
            if (m_y == YS - 1) begin
                m_y = 0; m_frames++; m_done = 1; m_chk = m_sum; m_sum = 0;
            end else begin
                m_y++;
            end
        end else begin
            m_x++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_tmo = 0; m_done = 0; m_rdy = 0;
            m_x = 0; m_y = 0; m_frames = 0; m_sof = 0; m_eol = 0; m_idle = 0; m_rel = 0;
            m_sum = 0; m_chk = 0; m_lfsr = 16'hACE1;
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            m_pre_lock = m_locked;
            m_acc = tvalid && m_rdy;
            m_done = 0;
            if (m_acc) m_beat(tuser, tlast, tdata);
            if (m_pre_lock) begin
                if (tvalid) m_idle = 0;
                else begin
                    if (m_idle < TO) m_idle++;
                    if (m_idle >= TO) m_tmo = 1;
                end
            end
            case (mode)
                2'd0:    m_rdy = 1;
                2'd1:    m_rdy = m_lfsr[15];
                2'd2:    m_rdy = tvalid && !m_rdy;
                default: m_rdy = 0;
            endcase
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    int   obs_done = 0;
    int   obs_acc  = 0;
    int   two_hi   = 0;
    bit   rdy_q    = 0;
    logic [1:0] mode_q = 2'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("rdy", tready, m_rdy);
            check("locked", locked, m_locked);
            check("x_pos", x_pos, m_x);
            check("y_pos", y_pos, m_y);
            check("frames", frame_count, m_frames);
            check("sof_err", sof_cnt, m_sof);
            check("eol_err", eol_cnt, m_eol);
            check("timeout", tmo, m_tmo);
            check("frame_done", fdone, m_done);
            check("checksum", chksum, m_chk);
            if (fdone) obs_done++;
            if (mode == 2'd2 && mode_q == 2'd2 && tready && rdy_q) two_hi++;
        end
        rdy_q  = tready;
        mode_q = mode;
    end

    task automatic send(input bit u, input bit l, input logic [31:0] d);
        bit got;
        got = 0;
        tvalid = 1; tuser = u; tlast = l; tdata = d;
        for (int n = 0; n < 100; n++) begin
            got = tready;
            @(negedge clk);
            if (got) break;
        end
        if (got) obs_acc++;
        else check("hs_wait", {31'd0, got}, 32'd1);
        tvalid = 0; tuser = 0; tlast = 0;
    endtask

    task automatic send_frame(input logic [31:0] base, input bit gaps);
        for (int i = 0; i < XS * YS; i++) begin
            send(i == 0, (i % XS) == XS - 1, base + i + 1);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    int d0, a0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rdy", tready, 0);
        check("rst_locked", locked, 0);
        check("rst_x", x_pos, 0);
        check("rst_y", y_pos, 0);
        check("rst_frames", frame_count, 0);
        check("rst_chk", chksum, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // Beats before the first SOF are dropped.
        for (int i = 0; i < 3; i++) send(0, i == 2, 32'd100 + i);
        check("hunt_locked", locked, 0);
        check("hunt_sof", sof_cnt, 0);
        check("hunt_eol", eol_cnt, 0);

        d0 = obs_done;
        send_frame(0, 0);
        send_frame(0, 0);
        @(negedge clk);
        check("m0_frames", frame_count, 2);
        check("m0_chk", chksum, 78);
        check("m0_done", obs_done - d0, 2);
        check("m0_errs", sof_cnt + eol_cnt, 0);

        mode = 2'd2;
        repeat (2) @(negedge clk);
        a0 = obs_acc;
        two_hi = 0;
        send_frame(0, 0);
        @(negedge clk);
        check("m2_acc", obs_acc - a0, 12);
        check("m2_chk", chksum, 78);
        check("m2_two_hi", two_hi, 0);

        mode = 2'd0;
        send(1, 0, 1); send(0, 0, 2); send(0, 1, 3);
        check("eol_cnt", eol_cnt, 1);
        check("eol_x", x_pos, 0);
        check("eol_y", y_pos, 1);
        for (int i = 0; i < 8; i++) send(0, (i % XS) == XS - 1, 10 + i);
        check("eol_frames", frame_count, 4);

        for (int i = 0; i < 4; i++) send(i == 0, i == 3, i);
        send(0, 0, 7); send(1, 0, 9);
        check("sof_cnt", sof_cnt, 1);
        check("sof_x", x_pos, 1);
        check("sof_y", y_pos, 0);
        check("sof_frames", frame_count, 4);
        for (int i = 1; i < 12; i++) send(0, (i % XS) == XS - 1, 20 + i);
        check("sof_done_frames", frame_count, 5);

        send(1, 0, 5);
        repeat (TO - 1) @(negedge clk);
        check("tmo_before", tmo, 0);
        @(negedge clk);
        check("tmo_set", tmo, 1);
        send(0, 0, 6);
        check("tmo_clear", tmo, 0);

        mode = 2'd3;
        @(negedge clk);
        tvalid = 1; tdata = 32'hDEAD;
        repeat (5) @(negedge clk);
        check("stall_rdy", tready, 0);
        check("stall_x", x_pos, 2);
        tvalid = 0; mode = 2'd0;
        @(negedge clk);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < XS * YS; i++) begin
                mode = 2'($urandom_range(0, 2));
                send((i == 0) ^ ($urandom_range(0, 19) == 0),
                     ((i % XS) == XS - 1) ^ ($urandom_range(0, 19) == 0), $urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        mode = 2'd0;
        @(negedge clk);
        send(1, 0, 1); send(0, 0, 2);
        #2 rst_n = 0;
        #1;
        check("arst_rdy", tready, 0);
        check("arst_locked", locked, 0);
        check("arst_x", x_pos, 0);
        check("arst_frames", frame_count, 0);
        check("arst_errs", sof_cnt + eol_cnt, 0);
        check("arst_chk", chksum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        send(0, 0, 3);
        check("post_rst_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
